// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline, owns mul/div start.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_sequencer #(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  input  logic [4:0]  if_id_rs1,
  input  logic [4:0]  if_id_rs2,
  input  logic        ex_branch_taken,
  input  logic        ex_mc_op,
  input  logic        mc_done,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        mc_go,
  output logic        mc_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_MC_WAIT
  } state_t;

  localparam bit          LP_WD_EN   = (MC_TIMEOUT != 0);
  localparam logic [15:0] LP_TO_LAST = 16'(MC_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_err;
  logic        w_err_set;
  logic        w_lu;
  logic        w_wd;
  logic        w_p2;
  logic        w_p34;

  assign w_lu = id_ex_memread && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign w_wd = LP_WD_EN && (r_state == S_MC_WAIT) &&
                (r_cnt == LP_TO_LAST) && !mc_done;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_go         = 1'b0;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_err_set     = 1'b0;
    w_p2          = 1'b0;
    w_p34         = 1'b0;

    unique case (r_state)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
          w_state_nxt = S_MEM_WAIT;
        end else begin
          w_p2 = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ready) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        end else begin
          w_p2 = 1'b1;
        end
      end
      S_MC_WAIT: begin
        // A watchdog expiry releases EX exactly like a real completion.
        if (mc_done || w_wd) begin
          w_p34     = 1'b1;
          w_err_set = w_wd;
        end else begin
          {pc_en, if_id_en, id_ex_en} = '0;
          ex_mem_bubble = 1'b1;
          w_cnt_nxt     = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase

    if (w_p2 && ex_mc_op) begin
      mc_go         = 1'b1;
      {pc_en, if_id_en, id_ex_en} = '0;
      ex_mem_bubble = 1'b1;
      w_cnt_nxt     = 16'd0;
      w_state_nxt   = S_MC_WAIT;
    end else if (w_p2 || w_p34) begin
      w_state_nxt = S_RUN;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_lu) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b0;
      mc_go         = 1'b0;
      w_state_nxt   = S_RUN;
      w_cnt_nxt     = 16'd0;
      w_err_set     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign mc_err = r_err;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall;
  logic [31:0] r_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= 32'd0;
      r_flush <= 32'd0;
    end else begin
      if (!pc_en) r_stall <= r_stall + 32'd1;
      if (if_id_flush || id_ex_flush) r_flush <= r_flush + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
  assign flush_events = r_flush;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule
